color_detect_axi_regs: RTL

AXI4-Lite slave register file for the ColorDetect2 IP, responding to the S00_AXI interface driven by the AXI4-Lite master BFM in the block-design bench. It holds four read/write 32-bit configuration registers at offsets 0x00-0x0C that feed the color-detect core. It also exposes one read-only status word from the core and pulses a per-register write strobe so the core can latch new settings.

---
 rtl/color_detect_axi_regs.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/color_detect_axi_regs.sv
// ColorDetect2 AXI4-Lite slave: four RW config words, one RO status word,
// and per-register write strobes toward the color-detect core.
module color_detect_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in,
  output logic [3:0]                      wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wstate_t;

  wstate_t       wstate;
  wstate_t       wnext;
  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [2:0]    aw_idx;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [2:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [DW-1:0] rd_mux;
  logic [DW-1:0] cfg [4];
  logic          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign cfg_reg0    = cfg[0];
  assign cfg_reg1    = cfg[1];
  assign cfg_reg2    = cfg[2];
  assign cfg_reg3    = cfg[3];

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    wnext = wstate;
    unique case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wnext = W_RESP;
        else if (aw_hs)    wnext = W_HAVE_A;
        else if (w_hs)     wnext = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)         wnext = W_RESP;
      W_HAVE_D: if (aw_hs)        wnext = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wnext = W_IDLE;
      default:                    wnext = W_IDLE;
    endcase
  end

  // Same-edge halves bypass the holding registers
  assign commit  = (wnext == W_RESP) && (wstate != W_RESP);
  assign wr_idx  = aw_hs ? S_AXI_AWADDR[4:2] : aw_idx;
  assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate        <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wr_pulse      <= '0;
      for (int i = 0; i < 4; i++) cfg[i] <= '0;
    end else begin
      wstate        <= wnext;
      S_AXI_AWREADY <= (wnext == W_IDLE) || (wnext == W_HAVE_D);
      S_AXI_WREADY  <= (wnext == W_IDLE) || (wnext == W_HAVE_A);
      wr_pulse      <= '0;
      if (aw_hs) aw_idx <= S_AXI_AWADDR[4:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        if (!wr_idx[2]) begin
          cfg[wr_idx[1:0]]      <= merge(cfg[wr_idx[1:0]], wr_data, wr_strb);
          wr_pulse[wr_idx[1:0]] <= 1'b1;
        end
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (S_AXI_ARADDR[4:2])
      3'd0:    rd_mux = cfg[0];
      3'd1:    rd_mux = cfg[1];
      3'd2:    rd_mux = cfg[2];
      3'd3:    rd_mux = cfg[3];
      3'd4:    rd_mux = status_in;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else if (ar_hs) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b1;
      S_AXI_RDATA   <= rd_mux;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
    end else if (!S_AXI_RVALID) begin
      S_AXI_ARREADY <= 1'b1;
    end
  end

endmodule
